// File: rtl/bist_pkg.sv
// Shared definitions for the BIST response analyzer: FSM encodings and MISR defaults.
package bist_pkg;
  localparam int          SIG_W    = 16;
  localparam logic [15:0] DEF_POLY = 16'h8016;
  localparam logic [15:0] DEF_SEED = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPACT = 2'd1,
    ST_COMPARE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;
endpackage

// File: rtl/bist_response_analyzer_if.sv
// Controller <-> analyzer bundle: run control, serial response stream, and result/status.
interface bist_response_analyzer_if #(
  parameter int SIG_W = bist_pkg::SIG_W
);
  logic             start;
  logic             sdo_valid;
  logic             cut_sdo;
  logic [SIG_W-1:0] golden_sig;
  logic             busy;
  logic             done;
  logic             pass;
  logic [SIG_W-1:0] signature;

  modport master (
    output start, sdo_valid, cut_sdo, golden_sig,
    input  busy, done, pass, signature
  );

  modport slave (
    input  start, sdo_valid, cut_sdo, golden_sig,
    output busy, done, pass, signature
  );
endinterface

// File: rtl/bist_response_analyzer_misr.sv
// Serial-input Galois MISR; clr reloads SEED and wins over en.
module misr_core #(
  parameter int               SIG_W = bist_pkg::SIG_W,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(bist_pkg::DEF_POLY),
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(bist_pkg::DEF_SEED)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             din,
  output logic [SIG_W-1:0] sig
);
  logic [SIG_W-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = SEED;
    end else if (en) begin
      sig_d = {sig_q[SIG_W-2:0], 1'b0}
            ^ (sig_q[SIG_W-1] ? POLY : '0)
            ^ {{(SIG_W-1){1'b0}}, din};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= SEED;
    else        sig_q <= sig_d;
  end

  assign sig = sig_q;
endmodule

// File: rtl/bist_response_analyzer.sv
// BIST response analyzer: run FSM, bit counter and golden compare around a MISR.
// Optional BIST_GOLDEN_CAPTURE_EN: first completed run after reset becomes the golden reference.
module bist_response_analyzer #(
  parameter int               TOTAL_BITS = 2000,
  parameter int               SIG_W      = bist_pkg::SIG_W,
  parameter logic [SIG_W-1:0] POLY       = SIG_W'(bist_pkg::DEF_POLY),
  parameter logic [SIG_W-1:0] SEED       = SIG_W'(bist_pkg::DEF_SEED)
) (
  input  logic                      clk,
  input  logic                      rst,
  bist_response_analyzer_if.slave   bus
);
  localparam int               CNT_W = $clog2(TOTAL_BITS + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TOTAL_BITS - 1);

  bist_pkg::state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [SIG_W-1:0] sig;
  logic [SIG_W-1:0] ref_sig;
  logic             start_ok;
  logic             shift_en;

`ifdef BIST_GOLDEN_CAPTURE_EN
  logic [SIG_W-1:0] cap_q, cap_d;
  logic             cap_vld_q, cap_vld_d;
  assign ref_sig = cap_q;
`else
  logic [SIG_W-1:0] golden_q, golden_d;
  assign ref_sig = golden_q;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    pass_d   = pass_q;
    start_ok = 1'b0;
    shift_en = 1'b0;
`ifdef BIST_GOLDEN_CAPTURE_EN
    cap_d     = cap_q;
    cap_vld_d = cap_vld_q;
`else
    golden_d  = golden_q;
`endif
    case (state_q)
      bist_pkg::ST_IDLE, bist_pkg::ST_DONE: begin
        if (bus.start) begin
          start_ok = 1'b1;
          cnt_d    = '0;
          done_d   = 1'b0;
          pass_d   = 1'b0;
`ifndef BIST_GOLDEN_CAPTURE_EN
          golden_d = bus.golden_sig;
`endif
          state_d  = bist_pkg::ST_COMPACT;
        end
      end
      bist_pkg::ST_COMPACT: begin
        // start is deliberately not looked at here: no restart while busy.
        if (bus.sdo_valid) begin
          shift_en = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) state_d = bist_pkg::ST_COMPARE;
        end
      end
      bist_pkg::ST_COMPARE: begin
        done_d  = 1'b1;
        state_d = bist_pkg::ST_DONE;
`ifdef BIST_GOLDEN_CAPTURE_EN
        if (!cap_vld_q) begin
          cap_d     = sig;
          cap_vld_d = 1'b1;
          pass_d    = 1'b1;
        end else begin
          pass_d    = (sig == ref_sig);
        end
`else
        pass_d  = (sig == ref_sig);
`endif
      end
      default: state_d = bist_pkg::ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= bist_pkg::ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

`ifdef BIST_GOLDEN_CAPTURE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_q     <= SEED;
      cap_vld_q <= 1'b0;
    end else begin
      cap_q     <= cap_d;
      cap_vld_q <= cap_vld_d;
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) golden_q <= '0;
    else      golden_q <= golden_d;
  end
`endif

  misr_core #(
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst),
    .en    (shift_en),
    .clr   (start_ok),
    .din   (bus.cut_sdo),
    .sig   (sig)
  );

  assign bus.busy      = (state_q == bist_pkg::ST_COMPACT) || (state_q == bist_pkg::ST_COMPARE);
  assign bus.done      = done_q;
  assign bus.pass      = pass_q & done_q;
  assign bus.signature = sig;
endmodule

// File: tb/tb_bist_response_analyzer.sv
// Directed + randomized bench for bist_response_analyzer with a polynomial-arithmetic reference model.
module tb_bist_response_analyzer;
  localparam int          TB_BITS = 4;
  localparam logic [15:0] P       = 16'h8016;
  localparam logic [15:0] S       = 16'h0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bist_response_analyzer_if #(.SIG_W(16)) bus();

  bist_response_analyzer #(
    .TOTAL_BITS (TB_BITS),
    .SIG_W      (16),
    .POLY       (P),
    .SEED       (S)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          tests = 0;
  int          fails = 0;
  logic        cap_v;
  logic [15:0] cap;

  // Signature = seed * x^n + sum(bit_k * x^(n-1-k)) reduced mod (x^16 + POLY).
  function automatic logic [15:0] model_sig(input logic [TB_BITS-1:0] bits);
    logic [16:0] acc;
    acc = {1'b0, S};
    for (int k = 0; k < TB_BITS; k++) begin
      acc = {acc[15:0], 1'b0} ^ {16'b0, bits[k]};
      if (acc[16]) acc = acc ^ {1'b1, P};
    end
    return acc[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One run: bits streamed bit0 first; vmode 0=every cycle, 1=alternate, 2=random gaps.
  task automatic do_run(input logic [TB_BITS-1:0] bits, input int vmode,
                        input logic [15:0] gold, input int start_cyc);
    logic [15:0] es;
    logic        ep;
    logic        v;
    int          i;
    int          cyc;
    bus.golden_sig = gold;
    bus.start      = 1'b1;
    bus.sdo_valid  = 1'b0;
    tick();
    bus.start      = 1'b0;
    bus.golden_sig = 16'($urandom);
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    chk("done_cleared",     32'(bus.done), 32'd0);
    i = 0; cyc = 0;
    while (i < TB_BITS && cyc < 64) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      bus.sdo_valid = v;
      bus.cut_sdo   = v ? bits[i] : 1'($urandom);
      bus.start     = (cyc == start_cyc);
      tick();
      if (v) i++;
      cyc++;
    end
    bus.sdo_valid = 1'b0;
    bus.start     = 1'b0;
    if (i < TB_BITS) chk("stream_timeout", 32'(i), 32'(TB_BITS));
    es = model_sig(bits);
`ifdef BIST_GOLDEN_CAPTURE_EN
    if (!cap_v) begin cap = es; cap_v = 1'b1; ep = 1'b1; end
    else        ep = (es == cap);
`else
    ep = (es == gold);
`endif
    chk("done_not_early", 32'(bus.done), 32'd0);
    cyc = 0;
    while (!bus.done && cyc < 8) begin tick(); cyc++; end
    chk("done",      32'(bus.done),      32'd1);
    chk("signature", 32'(bus.signature), 32'(es));
    chk("pass",      32'(bus.pass),      32'(ep));
    chk("busy_idle", 32'(bus.busy),      32'd0);
    // Valid bits after completion must not disturb the held result.
    for (int k = 0; k < 2; k++) begin
      bus.sdo_valid = 1'b1;
      bus.cut_sdo   = 1'($urandom);
      tick();
    end
    bus.sdo_valid = 1'b0;
    chk("sig_held_in_done",  32'(bus.signature), 32'(es));
    chk("done_sticky",       32'(bus.done),      32'd1);
    chk("pass_held_in_done", 32'(bus.pass),      32'(ep));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst   = 1'b1;
    cap_v = 1'b0;
    tick();
  endtask

  initial begin
    bus.start = 1'b0; bus.sdo_valid = 1'b0; bus.cut_sdo = 1'b0; bus.golden_sig = '0;
    cap_v = 1'b0; cap = '0;
    do_reset();
    chk("rst_busy", 32'(bus.busy),      32'd0);
    chk("rst_done", 32'(bus.done),      32'd0);
    chk("rst_pass", 32'(bus.pass),      32'd0);
    chk("rst_sig",  32'(bus.signature), 32'(S));

    // Valid bits while idle are ignored.
    bus.sdo_valid = 1'b1; bus.cut_sdo = 1'b1;
    tick(); tick();
    bus.sdo_valid = 1'b0;
    chk("idle_sig_hold", 32'(bus.signature), 32'(S));

    // Case 1/2/3: stream 1,0,0,0.
    do_run(4'b0001, 0, 16'h0008, -1);
    chk("case1_sig", 32'(bus.signature), 32'h0008);
    do_run(4'b0001, 0, 16'h0009, -1);
    chk("case2_sig", 32'(bus.signature), 32'h0008);
    do_run(4'b0001, 1, 16'h0008, -1);

    // Case 4: async reset after two bits aborts the run.
    bus.golden_sig = 16'h0008; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.sdo_valid = 1'b1; bus.cut_sdo = 1'b1;
    tick();
    bus.cut_sdo = 1'b0;
    tick();
    bus.sdo_valid = 1'b0;
    rst = 1'b0;
    #2;
    chk("abort_busy", 32'(bus.busy),      32'd0);
    chk("abort_done", 32'(bus.done),      32'd0);
    chk("abort_pass", 32'(bus.pass),      32'd0);
    chk("abort_sig",  32'(bus.signature), 32'(S));
    tick();
    rst   = 1'b1;
    cap_v = 1'b0;
    tick();
    do_run(4'b0001, 0, 16'h0008, -1);

    // Case 5: start mid-run, and start coinciding with the last bit, are both ignored.
    do_run(4'b1011, 0, 16'($urandom), 2);
    do_run(4'b0110, 0, model_sig(4'b0110), 3);

    // Case 6: A, A (unrelated golden_sig), B.
    do_reset();
    do_run(4'b0001, 0, 16'h0008, -1);
    do_run(4'b0001, 0, 16'($urandom) | 16'h8000, -1);
    do_run(4'b0011, 0, 16'h0008, -1);

    // Randomized runs with random valid gaps.
    for (int r = 0; r < 10; r++) begin
      logic [TB_BITS-1:0] b;
      b = TB_BITS'($urandom);
      do_run(b, 2, ($urandom_range(0, 1) != 0) ? model_sig(b) : 16'($urandom), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
